// File: rtl/axis_frame_scheduler.sv
// Frame-synchronous N:1 AXI4-Stream scheduler: one source per frame, switching only at frame ends.
// Optional statistics counters are enabled with `define AXIS_FRAME_SCHED_STATS_EN.
module axis_frame_scheduler #(
    parameter int N_SRC          = 2,
    parameter int DATA_WIDTH     = 16,
    parameter int USER_WIDTH     = 1,
    parameter int V_RES          = 768,
    parameter int FRAMES_PER_SRC = 60,
    parameter int DRAIN_UNSEL    = 1,
    parameter int SEL_W          = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_SRC-1:0]            s_tvalid_i,
    input  logic [N_SRC*DATA_WIDTH-1:0] s_tdata_i,
    input  logic [N_SRC-1:0]            s_tlast_i,
    input  logic [N_SRC*USER_WIDTH-1:0] s_tuser_i,
    output logic [N_SRC-1:0]            s_tready_o,
    output logic                        m_tvalid_o,
    output logic [DATA_WIDTH-1:0]       m_tdata_o,
    output logic                        m_tlast_o,
    output logic [USER_WIDTH-1:0]       m_tuser_o,
    input  logic                        m_tready_i,
    input  logic                        mode_i,
    input  logic [SEL_W-1:0]            sel_i,
    output logic [SEL_W-1:0]            cur_sel_o,
    output logic                        frame_done_o,
`ifdef AXIS_FRAME_SCHED_STATS_EN
    output logic [31:0]                 frame_cnt_o,
    output logic [31:0]                 underrun_cnt_o,
`endif
    output logic                        sync_err_o
);
    localparam int LC_W = $clog2(V_RES + 1);
    localparam int FC_W = $clog2(FRAMES_PER_SRC + 1);

    typedef enum logic {SYNC, STREAM} state_t;

    state_t                  state;
    logic [SEL_W-1:0]        act, nxt_act;
    logic [LC_W-1:0]         line_cnt;
    logic [FC_W-1:0]         frm_cnt, nxt_frm;
    logic                    first;

    logic                    a_valid, a_last, a_sof, act_ready, load_ok, hs, fwd, frame_end;
    logic [DATA_WIDTH-1:0]   a_data;
    logic [USER_WIDTH-1:0]   a_user;

    always_comb begin
        a_valid = 1'b0;
        a_data  = '0;
        a_last  = 1'b0;
        a_user  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (act == SEL_W'(k)) begin
                a_valid = s_tvalid_i[k];
                a_data  = s_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                a_last  = s_tlast_i[k];
                a_user  = s_tuser_i[k*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    assign a_sof     = a_user[0];
    assign load_ok   = !m_tvalid_o || m_tready_i;
    // While hunting for SOF, non-SOF beats are swallowed regardless of the output stage.
    assign act_ready = (state == SYNC && !a_sof) ? 1'b1 : load_ok;
    assign hs        = a_valid && act_ready && !rst_i;
    assign fwd       = hs && (state == STREAM || a_sof);
    assign frame_end = hs && state == STREAM && a_last && line_cnt == LC_W'(V_RES - 1);
    assign cur_sel_o = act;

    always_comb begin
        for (int k = 0; k < N_SRC; k++) begin
            if (rst_i)
                s_tready_o[k] = 1'b0;
            else if (act == SEL_W'(k))
                s_tready_o[k] = act_ready;
            else
                s_tready_o[k] = (DRAIN_UNSEL != 0);
        end
    end

    always_comb begin
        nxt_act = act;
        nxt_frm = '0;
        if (!mode_i) begin
            if (int'(sel_i) < N_SRC)
                nxt_act = sel_i;
        end else if (frm_cnt == FC_W'(FRAMES_PER_SRC - 1)) begin
            nxt_act = (act == SEL_W'(N_SRC - 1)) ? '0 : act + SEL_W'(1);
        end else begin
            nxt_frm = frm_cnt + FC_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= SYNC;
            act          <= '0;
            line_cnt     <= '0;
            frm_cnt      <= '0;
            first        <= 1'b1;
            m_tvalid_o   <= 1'b0;
            m_tdata_o    <= '0;
            m_tlast_o    <= 1'b0;
            m_tuser_o    <= '0;
            frame_done_o <= 1'b0;
            sync_err_o   <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            sync_err_o   <= 1'b0;
            if (load_ok) begin
                m_tvalid_o <= fwd;
                if (fwd) begin
                    m_tdata_o <= a_data;
                    m_tlast_o <= a_last;
                    m_tuser_o <= a_user;
                end
            end
            case (state)
                SYNC: begin
                    if (hs && a_sof) begin
                        line_cnt <= '0;
                        first    <= 1'b0;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        if (a_sof && !first)
                            sync_err_o <= 1'b1;
                        if (frame_end) begin
                            frame_done_o <= 1'b1;
                            line_cnt     <= '0;
                            act          <= nxt_act;
                            frm_cnt      <= nxt_frm;
                            first        <= 1'b1;
                            state        <= SYNC;
                        end else if (a_sof && !first) begin
                            // Stray SOF restarts the line count as a new frame.
                            line_cnt <= a_last ? LC_W'(1) : '0;
                        end else if (a_last) begin
                            line_cnt <= line_cnt + LC_W'(1);
                        end
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

`ifdef AXIS_FRAME_SCHED_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_cnt_o    <= '0;
            underrun_cnt_o <= '0;
        end else begin
            if (frame_end)
                frame_cnt_o <= frame_cnt_o + 32'd1;
            if (state == STREAM && m_tready_i && !m_tvalid_o && underrun_cnt_o != '1)
                underrun_cnt_o <= underrun_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_frame_scheduler.sv
// Scoreboard bench for axis_frame_scheduler: V_RES=3, 4 beats/line, 2 sources, 2 frames per source.
module tb_axis_frame_scheduler;
    localparam int N  = 2;
    localparam int DW = 16;
    localparam int UW = 1;
    localparam int FB = 12;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic [N-1:0]    s_tvalid_i = '0;
    logic [N*DW-1:0] s_tdata_i = '0;
    logic [N-1:0]    s_tlast_i = '0;
    logic [N*UW-1:0] s_tuser_i = '0;
    logic [N-1:0]    s_tready_o;
    logic            m_tvalid_o;
    logic [DW-1:0]   m_tdata_o;
    logic            m_tlast_o;
    logic [UW-1:0]   m_tuser_o;
    logic            m_tready_i = 1'b1;
    logic            mode_i = 1'b0;
    logic [0:0]      sel_i = '0;
    logic [0:0]      cur_sel_o;
    logic            frame_done_o;
    logic            sync_err_o;
`ifdef AXIS_FRAME_SCHED_STATS_EN
    logic [31:0]     frame_cnt_o, underrun_cnt_o;
`endif

    always #5 clk = ~clk;

    axis_frame_scheduler #(
        .N_SRC(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .V_RES(3),
        .FRAMES_PER_SRC(2), .DRAIN_UNSEL(1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .s_tvalid_i(s_tvalid_i), .s_tdata_i(s_tdata_i), .s_tlast_i(s_tlast_i),
        .s_tuser_i(s_tuser_i), .s_tready_o(s_tready_o),
        .m_tvalid_o(m_tvalid_o), .m_tdata_o(m_tdata_o), .m_tlast_o(m_tlast_o),
        .m_tuser_o(m_tuser_o), .m_tready_i(m_tready_i),
        .mode_i(mode_i), .sel_i(sel_i), .cur_sel_o(cur_sel_o),
        .frame_done_o(frame_done_o),
`ifdef AXIS_FRAME_SCHED_STATS_EN
        .frame_cnt_o(frame_cnt_o), .underrun_cnt_o(underrun_cnt_o),
`endif
        .sync_err_o(sync_err_o)
    );

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic        user;
        logic        fd;
        logic        se;
        logic        sel;
    } exp_t;

    typedef struct {
        logic       mode;
        logic       sel;
        logic       stall;
        int         nfr;
        logic [7:0] seq;   // bit f = source of frame f; bit nfr = source after the last frame
    } vec_t;

    exp_t  q[$];
    int    cnt[N];
    int    total = 0, bad = 0, obs = 0, cyc = 0;
    int    sw_at = -1, rst_at = -1;
    logic  stall = 1'b0, mid = 1'b0, after_rst = 1'b0, inj = 1'b0, prev_stall = 1'b0;
    logic [17:0] prev_out;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic void push_beat(int src, int idx, logic fd, logic se, logic sel);
        exp_t e;
        e.data = {4'(src), 4'h5, 8'(idx)};
        e.last = (idx % 4 == 3);
        e.user = (idx == 0);
        e.fd   = fd;
        e.se   = se;
        e.sel  = sel;
        q.push_back(e);
    endfunction

    function automatic void push_frame(int src, logic nxt);
        for (int i = 0; i < FB; i++)
            push_beat(src, i, i == FB - 1, 1'b0, (i == FB - 1) ? nxt : 1'(src));
    endfunction

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (rst_i && mid) begin
            rst_i = 1'b0; mid = 1'b0; after_rst = 1'b1;
        end else if (rst_at >= 0 && obs == rst_at) begin
            rst_i = 1'b1; rst_at = -1; mid = 1'b1;
        end
        if (sw_at >= 0 && obs == sw_at) begin
            sel_i = 1'b1; sw_at = -1;
        end
        if (inj && cnt[0] == 5) begin
            cnt[0] = 0; inj = 1'b0;
        end
        for (int s = 0; s < N; s++) begin
            s_tvalid_i[s]          = 1'b1;
            s_tdata_i[s*DW +: DW]  = {4'(s), 4'h5, 8'(cnt[s])};
            s_tlast_i[s]           = (cnt[s] % 4 == 3);
            s_tuser_i[s]           = (cnt[s] == 0);
        end
        m_tready_i = stall ? (cyc % 2 == 0) : 1'b1;
        #4;
        if (rst_i) begin
            chk("rst_tready", 32'(s_tready_o), 32'd0);
            prev_stall = 1'b0;
        end else begin
            if (after_rst) begin
                chk("midrst_mvalid", 32'(m_tvalid_o), 32'd0);
                chk("midrst_cursel", 32'(cur_sel_o), 32'd0);
                after_rst = 1'b0;
            end
            if (m_tvalid_o && prev_stall)
                chk("stall_hold", 32'({m_tdata_o, m_tlast_o, m_tuser_o}), 32'(prev_out));
            if (m_tvalid_o && !prev_stall) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_beat: got data %h want none", m_tdata_o);
                end else begin
                    chk("frame_done", 32'(frame_done_o), 32'(q[0].fd));
                    chk("sync_err", 32'(sync_err_o), 32'(q[0].se));
                    chk("cur_sel", 32'(cur_sel_o), 32'(q[0].sel));
                end
            end else begin
                chk("fd_idle", 32'(frame_done_o), 32'd0);
                chk("se_idle", 32'(sync_err_o), 32'd0);
            end
            if (m_tvalid_o && m_tready_i && q.size() > 0) begin
                e = q.pop_front();
                chk("beat", 32'({m_tdata_o, m_tlast_o, m_tuser_o}), 32'({e.data, e.last, e.user}));
                obs++;
            end
            prev_stall = m_tvalid_o && !m_tready_i;
            prev_out   = {m_tdata_o, m_tlast_o, m_tuser_o};
        end
        for (int s = 0; s < N; s++)
            if (s_tvalid_i[s] && s_tready_o[s])
                cnt[s] = (cnt[s] + 1) % FB;
        cyc++;
    endtask

    task automatic run(input string nm);
        int n = 0;
        while (q.size() > 0 && n < 600) begin
            cycle();
            n++;
        end
        if (q.size() > 0) begin
            total++; bad++;
            $display("FAIL %s timeout: %0d beats outstanding, want 0", nm, q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cycle();
        cycle();
        #2;
        chk("rst_mout", 32'({m_tvalid_o, m_tdata_o, m_tlast_o, m_tuser_o}), 32'd0);
        chk("rst_flags", 32'({frame_done_o, sync_err_o, cur_sel_o}), 32'd0);
        rst_i = 1'b0;
        for (int s = 0; s < N; s++) cnt[s] = 0;
        prev_stall = 1'b0;
        obs = 0;
    endtask

    initial begin
        vec_t vt[5];
        vt[0] = '{mode: 1'b0, sel: 1'b0, stall: 1'b0, nfr: 1, seq: 8'h00};
        vt[1] = '{mode: 1'b1, sel: 1'b0, stall: 1'b0, nfr: 6, seq: 8'h4C};
        vt[2] = '{mode: 1'b0, sel: 1'b0, stall: 1'b1, nfr: 1, seq: 8'h00};
        vt[3] = '{mode: 1'b0, sel: 1'b1, stall: 1'b0, nfr: 2, seq: 8'h06};
        vt[4] = '{mode: 1'b1, sel: 1'b0, stall: 1'b1, nfr: 3, seq: 8'h0C};
        for (int s = 0; s < N; s++) cnt[s] = 0;

        for (int v = 0; v < 5; v++) begin
            mode_i = vt[v].mode;
            sel_i  = vt[v].sel;
            stall  = vt[v].stall;
            do_reset();
            for (int f = 0; f < vt[v].nfr; f++)
                push_frame(int'(vt[v].seq[f]), vt[v].seq[f+1]);
            run($sformatf("vec%0d", v));
        end

        // manual switch 0->1 mid-frame takes effect at the frame end
        mode_i = 1'b0; sel_i = 1'b0; stall = 1'b0;
        do_reset();
        sw_at = 5;
        push_frame(0, 1'b1);
        push_frame(1, 1'b1);
        run("switch");
        sw_at = -1;

        // stray SOF on the 6th beat restarts the frame
        sel_i = 1'b0;
        do_reset();
        inj = 1'b1;
        for (int i = 0; i < 5; i++) push_beat(0, i, 1'b0, 1'b0, 1'b0);
        push_beat(0, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < FB; i++) push_beat(0, i, i == FB - 1, 1'b0, 1'b0);
        run("sync_err");
        inj = 1'b0;

        // one-cycle reset after the 7th beat: resume at the next src0 SOF
        do_reset();
        rst_at = 7;
        for (int i = 0; i < 7; i++) push_beat(0, i, 1'b0, 1'b0, 1'b0);
        push_frame(0, 1'b0);
        run("midrst");
        rst_at = -1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
